// File: rtl/pooling_pkg.sv
// Shared FP32 helpers and elaboration checks for the max-pooling stream engine.
// The lane width comes from the global DATA_WIDTH define when one is supplied.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

`ifndef POOLING_PARAM_CHECK
`define POOLING_PARAM_CHECK(ch, k) \
    if ((ch) < 1 || (k) < 2) begin : g_param_check \
        $error("pooling: CHANNELS must be >= 1 and KERNEL >= 2"); \
    end
`endif

package pooling_pkg;

    localparam logic [31:0] FP32_CANON_NAN = 32'h7FC0_0000;

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pooling_max_stream_if.sv
// Pixel-in / window-max-out stream bundle; the master produces pixels and consumes maxima.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface pooling_max_stream_if #(
    parameter int CHANNELS = 4,
    parameter int ROW_W    = 1,
    parameter int COL_W    = 1
);
    logic                            in_valid;
    logic                            in_ready;
    logic [CHANNELS*`DATA_WIDTH-1:0] in_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [CHANNELS*`DATA_WIDTH-1:0] out_data;
    logic [ROW_W-1:0]                out_row;
    logic [COL_W-1:0]                out_col;
    logic                            out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_row, out_col, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_row, out_col, out_last
    );
endinterface

// File: rtl/fp32_max2.sv
// Combinational FP32 maximum: NaN in either operand yields canonical NaN,
// +0 equals -0, and the held operand a wins every tie.
module fp32_max2
    import pooling_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic both_zero;
    logic b_gt;

    assign both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);

    always_comb begin
        b_gt = 1'b0;
        if (both_zero) begin
            b_gt = 1'b0;
        end else if (a[31] != b[31]) begin
            b_gt = a[31];
        end else if (!a[31]) begin
            b_gt = (b[30:0] > a[30:0]);
        end else begin
            // Both negative: smaller magnitude is the larger value.
            b_gt = (b[30:0] < a[30:0]);
        end

        if (is_nan(a) || is_nan(b)) begin
            y = FP32_CANON_NAN;
        end else begin
            y = b_gt ? b : a;
        end
    end
endmodule

// File: rtl/pooling_max_stream.sv
// Channel-parallel FP32 max pooling over non-overlapping KERNEL x KERNEL windows
// of a raster stream, with a one-row line buffer of partial column maxima.
module pooling_max_stream
    import pooling_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int IN_COLS  = 24,
    parameter int IN_ROWS  = 24,
    parameter int KERNEL   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    pooling_max_stream_if.slave bus
);
    localparam int DW       = `DATA_WIDTH;
    localparam int LANES_W  = CHANNELS * DW;
    localparam int OUT_COLS = IN_COLS / KERNEL;
    localparam int OUT_ROWS = IN_ROWS / KERNEL;
    localparam int KX_W     = cnt_w(KERNEL);
    localparam int OC_W     = cnt_w(OUT_COLS);
    localparam int OR_W     = cnt_w(OUT_ROWS);
    localparam logic [KX_W-1:0] K_LAST  = KX_W'(KERNEL - 1);
    localparam logic [OC_W-1:0] OC_LAST = OC_W'(OUT_COLS - 1);
    localparam logic [OR_W-1:0] OR_LAST = OR_W'(OUT_ROWS - 1);

    `POOLING_PARAM_CHECK(CHANNELS, KERNEL)

    if ((IN_COLS % KERNEL) != 0 || (IN_ROWS % KERNEL) != 0) begin : g_map_check
        $error("pooling_max_stream: map size must be a multiple of KERNEL");
    end

    logic [KX_W-1:0]    kx_reg, ky_reg;
    logic [OC_W-1:0]    oc_reg;
    logic [OR_W-1:0]    orow_reg;
    logic [LANES_W-1:0] acc_reg;
    logic [LANES_W-1:0] acc_next, h_all, v_all, line_wr;
    logic [LANES_W-1:0] line_rd_reg;
    logic [LANES_W-1:0] line_mem [OUT_COLS];

    logic               out_valid_reg;
    logic [LANES_W-1:0] out_data_reg;
    logic [OR_W-1:0]    out_row_reg;
    logic [OC_W-1:0]    out_col_reg;
    logic               out_last_reg;

    logic in_ready, accept;
    logic kx_last, ky_last, oc_last, orow_last;

    assign in_ready  = !(out_valid_reg && !bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign kx_last   = (kx_reg == K_LAST);
    assign ky_last   = (ky_reg == K_LAST);
    assign oc_last   = (oc_reg == OC_LAST);
    assign orow_last = (orow_reg == OR_LAST);
    assign acc_next  = (kx_reg == '0) ? bus.in_data : h_all;
    assign line_wr   = (ky_reg == '0) ? h_all : v_all;

    // Lane 0 occupies the most significant slice of every bus.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
        localparam int LO = (CHANNELS - 1 - gi) * DW;
        fp32_max2 u_h (.a(acc_reg[LO +: DW]),     .b(bus.in_data[LO +: DW]), .y(h_all[LO +: DW]));
        fp32_max2 u_v (.a(line_rd_reg[LO +: DW]), .b(h_all[LO +: DW]),       .y(v_all[LO +: DW]));
    end

    // oc is constant across a window and KERNEL >= 2, so the registered read
    // of line[oc] is always settled by the window's completing beat.
    always_ff @(posedge clk) begin
        if (accept && !flush && kx_last && !ky_last)
            line_mem[oc_reg] <= line_wr;
        line_rd_reg <= line_mem[oc_reg];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kx_reg        <= '0;
            ky_reg        <= '0;
            oc_reg        <= '0;
            orow_reg      <= '0;
            acc_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_row_reg   <= '0;
            out_col_reg   <= '0;
            out_last_reg  <= 1'b0;
        end else if (flush) begin
            kx_reg        <= '0;
            ky_reg        <= '0;
            oc_reg        <= '0;
            orow_reg      <= '0;
            acc_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (bus.out_ready)
                out_valid_reg <= 1'b0;
            if (accept) begin
                acc_reg <= acc_next;
                kx_reg  <= kx_last ? '0 : kx_reg + 1'b1;
                if (kx_last) begin
                    oc_reg <= oc_last ? '0 : oc_reg + 1'b1;
                    if (oc_last) begin
                        ky_reg <= ky_last ? '0 : ky_reg + 1'b1;
                        if (ky_last)
                            orow_reg <= orow_last ? '0 : orow_reg + 1'b1;
                    end
                    if (ky_last) begin
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= v_all;
                        out_row_reg   <= orow_reg;
                        out_col_reg   <= oc_reg;
                        out_last_reg  <= oc_last && orow_last;
                    end
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_row   = out_row_reg;
    assign bus.out_col   = out_col_reg;
    assign bus.out_last  = out_last_reg;
endmodule

// File: tb/tb_pooling_max_stream.sv
// Directed bench: DUT A (4 lanes, 4x4, K=2) for function/backpressure/reset,
// DUT B (4 lanes, 6x6, K=3) for random-gap frames, flush and mid-frame reset.
module tb_pooling_max_stream;

    typedef struct packed {
        logic [127:0] data;
        logic         row;
        logic         col;
        logic         last;
    } obs_t;

    localparam logic [31:0] ONE = 32'h3F80_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_acc_a = 0;
    obs_t qa[$];
    obs_t qb[$];
    obs_t ea[$];
    obs_t eb[$];

    pooling_max_stream_if #(.CHANNELS(4), .ROW_W(1), .COL_W(1)) ia ();
    pooling_max_stream_if #(.CHANNELS(4), .ROW_W(1), .COL_W(1)) ib ();

    pooling_max_stream #(.CHANNELS(4), .IN_COLS(4), .IN_ROWS(4), .KERNEL(2)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .bus(ia.slave)
    );
    pooling_max_stream #(.CHANNELS(4), .IN_COLS(6), .IN_ROWS(6), .KERNEL(3)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .bus(ib.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ia.out_valid && ia.out_ready)
            qa.push_back({ia.out_data, ia.out_row, ia.out_col, ia.out_last});
        if (ib.out_valid && ib.out_ready)
            qb.push_back({ib.out_data, ib.out_row, ib.out_col, ib.out_last});
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] i2f(input int v);
        logic [31:0] m;
        int e;
        if (v == 0) return 32'h0;
        m = (v < 0) ? 32'(-v) : 32'(v);
        e = 31;
        while (m[e] == 1'b0) e--;
        return {v < 0, 8'(e + 127), 23'(m << (23 - e))};
    endfunction

    function automatic logic [127:0] ramp_pix(input int i);
        return {i2f(i), i2f(-i), ONE, ONE};
    endfunction

    function automatic obs_t ramp_exp(input int k);
        obs_t e;
        case (k)
            0:       e.data = {32'h40A00000, 32'h00000000, ONE, ONE};
            1:       e.data = {32'h40E00000, 32'hC0000000, ONE, ONE};
            2:       e.data = {32'h41500000, 32'hC1000000, ONE, ONE};
            default: e.data = {32'h41700000, 32'hC1200000, ONE, ONE};
        endcase
        e.row  = k[1];
        e.col  = k[0];
        e.last = (k == 3);
        return e;
    endfunction

    function automatic logic [127:0] nz_pix(input int r, input int c);
        logic [31:0] l0, l1, l2, l3;
        l0 = ONE; l1 = ONE; l2 = ONE; l3 = ONE;
        if (r == 0 && c == 0) begin l0 = 32'hC0400000; l1 = 32'h00000000; end
        if (r == 0 && c == 1) begin l0 = 32'hBF800000; l1 = 32'h80000000; end
        if (r == 1 && c == 0) begin l0 = 32'hC0000000; l1 = 32'hC0A00000; end
        if (r == 1 && c == 1) begin l0 = 32'h80000000; l1 = 32'hC0C00000; end
        if (r == 1 && c == 3) l2 = 32'h7F800001;
        if (r == 2 && c == 0) l3 = 32'h7F800001;
        return {l0, l1, l2, l3};
    endfunction

    function automatic obs_t nz_exp(input int k);
        obs_t e;
        case (k)
            0:       e.data = {32'h80000000, 32'h00000000, ONE, ONE};
            1:       e.data = {ONE, ONE, 32'h7FC00000, ONE};
            2:       e.data = {ONE, ONE, ONE, 32'h7FC00000};
            default: e.data = {ONE, ONE, ONE, ONE};
        endcase
        e.row  = k[1];
        e.col  = k[0];
        e.last = (k == 3);
        return e;
    endfunction

    task automatic send(input bit sel, input logic [127:0] d);
        bit taken;
        int guard;
        taken = 1'b0;
        guard = 0;
        if (sel) begin ib.in_valid = 1'b1; ib.in_data = d; end
        else     begin ia.in_valid = 1'b1; ia.in_data = d; end
        while (!taken && guard < 200) begin
            @(negedge clk);
            taken = sel ? ib.in_ready : ia.in_ready;
            if (taken && !sel) n_acc_a++;
            @(posedge clk); #1;
            guard++;
        end
        if (!taken) check("send_timeout", 128'(taken), 128'(1));
        if (sel) ib.in_valid = 1'b0; else ia.in_valid = 1'b0;
    endtask

    task automatic check_q(input bit sel, input string tag);
        obs_t got[$];
        obs_t want[$];
        if (sel) begin got = qb; want = eb; qb.delete(); eb.delete(); end
        else     begin got = qa; want = ea; qa.delete(); ea.delete(); end
        check({tag, "_count"}, 128'(got.size()), 128'(want.size()));
        for (int i = 0; i < got.size() && i < want.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), got[i].data, want[i].data);
            check($sformatf("%s_pos%0d", tag, i),
                  128'({got[i].row, got[i].col, got[i].last}),
                  128'({want[i].row, want[i].col, want[i].last}));
        end
    endtask

    // Random 6x6x4 integer frame; the scoreboard takes integer window maxima.
    task automatic frame_b(input int n_beats, input bit gaps);
        int px [6][6][4];
        int m;
        obs_t e;
        logic [127:0] d;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                for (int l = 0; l < 4; l++)
                    px[r][c][l] = int'($urandom_range(0, 2000)) - 1000;
        if (n_beats == 36) begin
            for (int wr = 0; wr < 2; wr++) begin
                for (int wc = 0; wc < 2; wc++) begin
                    for (int l = 0; l < 4; l++) begin
                        m = px[wr*3][wc*3][l];
                        for (int dy = 0; dy < 3; dy++)
                            for (int dx = 0; dx < 3; dx++)
                                if (px[wr*3+dy][wc*3+dx][l] > m) m = px[wr*3+dy][wc*3+dx][l];
                        e.data[(3-l)*32 +: 32] = i2f(m);
                    end
                    e.row  = 1'(wr);
                    e.col  = 1'(wc);
                    e.last = (wr == 1 && wc == 1);
                    eb.push_back(e);
                end
            end
        end
        for (int i = 0; i < n_beats; i++) begin
            if (gaps) begin
                ib.in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            for (int l = 0; l < 4; l++) d[(3-l)*32 +: 32] = i2f(px[i/6][i%6][l]);
            send(1'b1, d);
        end
    endtask

    initial begin
        obs_t e0;
        int   g;
        ia.in_valid = 1'b0; ia.in_data = '0; ia.out_ready = 1'b1;
        ib.in_valid = 1'b0; ib.in_data = '0; ib.out_ready = 1'b1;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(ia.out_valid), 128'(0));
        check("rst_out_data",  ia.out_data, 128'(0));
        check("rst_out_row",   128'(ia.out_row), 128'(0));
        check("rst_out_col",   128'(ia.out_col), 128'(0));
        check("rst_out_last",  128'(ia.out_last), 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready",  128'(ia.in_ready), 128'(1));
        check("rst_b_valid",   128'(ib.out_valid), 128'(0));

        // Ramp 4x4 frame
        for (int i = 0; i < 4; i++) ea.push_back(ramp_exp(i));
        for (int i = 0; i < 16; i++) send(1'b0, ramp_pix(i));
        repeat (3) @(posedge clk); #1;
        check_q(1'b0, "ramp");

        // Negatives, signed zeros and NaN
        for (int i = 0; i < 4; i++) ea.push_back(nz_exp(i));
        for (int i = 0; i < 16; i++) send(1'b0, nz_pix(i / 4, i % 4));
        repeat (3) @(posedge clk); #1;
        check_q(1'b0, "negzero_nan");

        // Backpressure: hold out_ready low 5 cycles on the first result
        n_acc_a = 0;
        e0 = ramp_exp(0);
        for (int i = 0; i < 4; i++) ea.push_back(ramp_exp(i));
        fork
            for (int i = 0; i < 16; i++) send(1'b0, ramp_pix(i));
            begin
                g = 0;
                do begin @(posedge clk); #1; g++; end while (!ia.out_valid && g < 60);
                check("bp_first_valid", 128'(ia.out_valid), 128'(1));
                check("bp_latency_beats", 128'(n_acc_a), 128'(6));
                ia.out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready_low", 128'(ia.in_ready), 128'(0));
                    check("bp_hold_valid", 128'(ia.out_valid), 128'(1));
                    check("bp_hold_data", ia.out_data, e0.data);
                    @(posedge clk); #1;
                end
                ia.out_ready = 1'b1;
                @(negedge clk);
                check("bp_in_ready_back", 128'(ia.in_ready), 128'(1));
            end
        join
        repeat (3) @(posedge clk); #1;
        check_q(1'b0, "bp");

        // Asynchronous reset while a result is pending, then a clean frame
        ia.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(1'b0, ramp_pix(i));
        check("arst_pre_valid", 128'(ia.out_valid), 128'(1));
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 128'(ia.out_valid), 128'(0));
        check("arst_data", ia.out_data, 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        ia.out_ready = 1'b1;
        qa.delete();
        for (int i = 0; i < 4; i++) ea.push_back(ramp_exp(i));
        for (int i = 0; i < 16; i++) send(1'b0, ramp_pix(i));
        repeat (3) @(posedge clk); #1;
        check_q(1'b0, "after_arst");

        // Back-to-back 6x6 K=3 frames with random input gaps
        for (int f = 0; f < 3; f++) frame_b(36, 1'b1);
        repeat (4) @(posedge clk); #1;
        check_q(1'b1, "frames");

        // Flush after 7 beats; a NaN beat offered in the flush cycle must vanish
        frame_b(7, 1'b0);
        flush = 1'b1;
        ib.in_valid = 1'b1;
        ib.in_data = {4{32'h7F800001}};
        @(posedge clk); #1;
        flush = 1'b0;
        ib.in_valid = 1'b0;
        frame_b(36, 1'b0);
        repeat (4) @(posedge clk); #1;
        check_q(1'b1, "flush");

        // Reset after 7 beats instead of flush
        frame_b(7, 1'b0);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        frame_b(36, 1'b1);
        repeat (4) @(posedge clk); #1;
        check_q(1'b1, "rst_mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
